mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Memory-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
//  Takes the EX/MEM address (ALU result), store data and access size.
//  Runs a req/ack transaction to data memory and returns the formatted load word to MEM/WB.
//  Asserts stall_o to freeze the pipeline while the access is outstanding.
// PARAMETERS
//  XLEN     64   data and address width; XLEN/8 byte strobes
//  TIMEOUT  255  cycles to wait for mem_ack_i before aborting; 0 = wait forever
// PORTS
//  clk          in   1          clock
//  reset        in   1          synchronous, active-high
//  memRead_i    in   1          load in the MEM stage
//  memWrite_i   in   1          store in the MEM stage
//  funct3_i     in   3          size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  addr_i       in   XLEN       effective byte address (ALU result)
//  wdata_i      in   XLEN       store data, right-aligned
//  stall_o      out  1          freeze IF..EX/MEM; insert bubble into MEM/WB
//  readData_o   out  XLEN       formatted load result to MEM/WB
//  misalign_o   out  1          1-cycle pulse: misaligned access, no memory op issued
//  busErr_o     out  1          1-cycle pulse: access aborted by timeout
//  mem_req_o    out  1          memory request
//  mem_we_o     out  1          1 = write
//  mem_addr_o   out  XLEN       doubleword-aligned address {addr[XLEN-1:3],3'b0}
//  mem_wdata_o  out  XLEN       store data shifted to byte lane addr[2:0]
//  mem_wstrb_o  out  XLEN/8     byte enables; 0 on reads
//  mem_rdata_i  in   XLEN       read data, valid while mem_ack_i=1
//  mem_ack_i    in   1          1-cycle completion
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; timeout counter 0.
//  op = (memRead_i|memWrite_i) & ~(memRead_i&memWrite_i); both high counts as no-op.
//  Misaligned: addr mod size != 0 (size 1/2/4/8 from funct3[1:0]).
//  FSM states: IDLE, WAIT, DONE.
//  IDLE:
//   - misaligned op: misalign_o=1 this cycle, stall_o=0, stay IDLE.
//   - aligned op: stall_o=1 (combinational); latch we, aligned address, shifted wdata, strobes, funct3, addr[2:0]; go to WAIT.
//  WAIT:
//   - mem_req_o=1; stall_o=1; all mem_* outputs stable until ack.
//   - on mem_ack_i: select lane addr[2:0], sign- or zero-extend per funct3 into readData_o (stores leave readData_o unchanged); go to DONE.
//   - if TIMEOUT!=0 and counter reaches TIMEOUT: busErr_o=1, readData_o=0, go to DONE.
//  DONE:
//   - stall_o=0; mem_req_o=0; go to IDLE.
//   - Pipeline advances at this edge, so the same op is never reissued.
//  mem_req_o is registered: first high the cycle after the op is accepted.
//  Minimum load/store latency is 3 cycles (accept, ack, done).
//  mem_ack_i in IDLE or DONE is ignored.
//  readData_o holds its value until the next completed load or reset.
//  Reset mid-WAIT: mem_req_o drops at the next edge; the late ack is ignored.
//  Counter clears on entry to WAIT and saturates at TIMEOUT.
//  Store strobes: B 1 bit, H 2 bits, W 4 bits, D all 8 bits, each shifted left by addr[2:0].
// TESTING
//  1. LB, addr=0x1003, rdata=0x0000_0000_8000_0000, ack on 1st WAIT cycle
//     -> readData_o=0xFFFF_FFFF_FFFF_FF80; stall high 2 cycles.
//  2. LHU, addr=0x1006, rdata=0xBEEF_0000_0000_0000, ack after 4 WAIT cycles
//     -> readData_o=0x0000_0000_0000_BEEF; mem_req_o high exactly 4 cycles.
//  3. SW, addr=0x2004, wdata=0x1234_5678
//     -> mem_wstrb_o=0xF0, mem_wdata_o=0x1234_5678_0000_0000, mem_addr_o=0x2000, mem_we_o=1.
//  4. LW, addr=0x3002
//     -> misalign_o pulse, mem_req_o stays 0, stall_o=0.
//  5. TIMEOUT=4, LD with no ack
//     -> busErr_o pulses in the 5th WAIT cycle, readData_o=0, FSM back in IDLE 2 cycles later.
//  6. Reset asserted in the 2nd WAIT cycle, ack 1 cycle later
//     -> mem_req_o=0, all outputs 0, readData_o unchanged by the ack.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit with req/ack data port.
// Ports: pipeline side (memRead/memWrite/funct3/addr/wdata -> stall/readData/misalign/busErr), memory side (mem_*).
module mem_lsu #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_i,
  input  logic              memWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   readData_o,
  output logic              misalign_o,
  output logic              busErr_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [NB-1:0]   r_wstrb;
  logic [2:0]      r_f3;
  logic [OB-1:0]   r_off;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rdata;

  logic            w_op;
  logic [OB-1:0]   w_off;
  logic [OB-1:0]   w_mask;
  logic [NB-1:0]   w_bstrb;
  logic            w_mis;
  logic            w_go;
  logic            w_tmo;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_fmt;

  // Both strobes high is treated as a bubble.
  assign w_op  = (memRead_i | memWrite_i)
               & ~(memRead_i & memWrite_i);
  assign w_off = addr_i[OB-1:0];

  always_comb begin
    w_mask  = '0;
    w_bstrb = '0;
    unique case (funct3_i[1:0])
      2'b00: begin
        w_mask  = OB'(0);
        w_bstrb = NB'(8'h01);
      end
      2'b01: begin
        w_mask  = OB'(1);
        w_bstrb = NB'(8'h03);
      end
      2'b10: begin
        w_mask  = OB'(3);
        w_bstrb = NB'(8'h0F);
      end
      default: begin
        w_mask  = OB'(7);
        w_bstrb = '1;
      end
    endcase
  end

  assign w_mis = |(w_off & w_mask);
  assign w_go  = (r_state == S_IDLE)
               & w_op & ~w_mis;
  assign w_tmo = (TIMEOUT != 0)
               && (r_cnt == TMAX);

  assign w_lane = mem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_fmt = w_lane;
    unique case (r_f3)
      3'b000: w_fmt = XLEN'($signed(w_lane[7:0]));
      3'b001: w_fmt = XLEN'($signed(w_lane[15:0]));
      3'b010: w_fmt = XLEN'($signed(w_lane[31:0]));
      3'b100: w_fmt = XLEN'(w_lane[7:0]);
      3'b101: w_fmt = XLEN'(w_lane[15:0]);
      3'b110: w_fmt = XLEN'(w_lane[31:0]);
      default: w_fmt = w_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_WAIT;
      S_WAIT: if (mem_ack_i || w_tmo)
                w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    busErr_o   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall_o    = w_op & ~w_mis;
        misalign_o = w_op & w_mis;
      end
      S_WAIT: begin
        stall_o  = 1'b1;
        busErr_o = ~mem_ack_i & w_tmo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else if (w_go) begin
      r_req   <= 1'b1;
      r_we    <= memWrite_i;
      r_addr  <= {addr_i[XLEN-1:OB], OB'(0)};
      r_wdata <= memWrite_i
               ? (wdata_i << {w_off, 3'b000})
               : '0;
      r_wstrb <= memWrite_i
               ? (w_bstrb << w_off) : '0;
      r_f3    <= funct3_i;
      r_off   <= w_off;
      r_cnt   <= '0;
    end else if (r_state == S_WAIT) begin
      if (mem_ack_i || w_tmo) begin
        // Drive the memory port back to idle.
        r_req   <= 1'b0;
        r_we    <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_wstrb <= '0;
        if (mem_ack_i) begin
          if (!r_we) r_rdata <= w_fmt;
        end else begin
          r_rdata <= '0;
        end
      end else if (r_cnt != TMAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign readData_o  = r_rdata;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_wstrb;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu.
// Directed loads/stores, misaligned, timeout and reset-abort cases.
module tb_mem_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memRead_i = 1'b0;
  logic        memWrite_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [63:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic        stall_o;
  logic [63:0] readData_o;
  logic        misalign_o;
  logic        busErr_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic [63:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  mem_lsu #(.XLEN(64), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .memRead_i(memRead_i),
    .memWrite_i(memWrite_i),
    .funct3_i(funct3_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .stall_o(stall_o),
    .readData_o(readData_o),
    .misalign_o(misalign_o),
    .busErr_o(busErr_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] rdata;
    int          nst;
    int          nrq;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic push(input int k, input logic we,
                      input logic [63:0] a, wd,
                      input logic [7:0] s,
                      input logic [63:0] rd,
                      input int nst, nrq);
    exp_t e;
    e.kind = k; e.we = we; e.addr = a;
    e.wdata = wd; e.strb = s; e.rdata = rd;
    e.nst = nst; e.nrq = nrq;
    q.push_back(e);
  endtask

  // d>0: ack in WAIT cycle d; d=0: never ack; d<0: misaligned.
  task automatic op(input logic rd, wr,
                    input logic [2:0] f3,
                    input logic [63:0] a, wd,
                    input int d,
                    input logic [63:0] rdat);
    memRead_i = rd; memWrite_i = wr;
    funct3_i = f3; addr_i = a; wdata_i = wd;
    @(posedge clk) #1;
    memRead_i = 1'b0; memWrite_i = 1'b0;
    if (d > 0) begin
      repeat (d - 1) @(posedge clk) #1;
      mem_ack_i = 1'b1; mem_rdata_i = rdat;
      @(posedge clk) #1;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      @(posedge clk) #1;
    end else if (d == 0) begin
      repeat (TMO + 2) @(posedge clk) #1;
    end
  endtask

  bit pend = 0;
  bit was_err = 0;
  int cst = 0;
  int crq = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pend = 0; cst = 0; crq = 0;
    end else if (pend) begin
      if (q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL sb_underflow: got response want none");
      end else begin
        e = q.pop_front();
        chk("kind", was_err ? 2 : 0, e.kind);
        chk("rdata", readData_o, e.rdata);
        chk("nstall", cst, e.nst);
        chk("nreq", crq, e.nrq);
        chk("done_stall", stall_o, 0);
        chk("done_req", mem_req_o, 0);
      end
      pend = 0; cst = 0; crq = 0;
    end else begin
      if (stall_o) cst++;
      if (mem_req_o) crq++;
      if (misalign_o) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL sb_underflow: got misalign want none");
        end else begin
          e = q.pop_front();
          chk("mis_kind", 1, e.kind);
          chk("mis_stall", stall_o, 0);
          chk("mis_req", crq, 0);
        end
        cst = 0; crq = 0;
      end
      if (mem_req_o && (mem_ack_i || busErr_o)) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL sb_underflow: got access want none");
        end else begin
          chk("maddr", mem_addr_o, q[0].addr);
          chk("mwe", mem_we_o, q[0].we);
          chk("mwdata", mem_wdata_o, q[0].wdata);
          chk("mwstrb", mem_wstrb_o, q[0].strb);
        end
        pend = 1; was_err = busErr_o;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_rdata", readData_o, 0);
    chk("rst_strb", mem_wstrb_o, 0);
    @(posedge clk) #1;
    reset = 1'b0;
    @(posedge clk) #1;

    push(0, 0, 64'h1000, 0, 8'h00,
         64'hFFFF_FFFF_FFFF_FF80, 2, 1);
    op(1, 0, 3'b000, 64'h1003, 0, 1,
       64'h0000_0000_8000_0000);

    push(0, 0, 64'h1000, 0, 8'h00,
         64'h0000_0000_0000_BEEF, 5, 4);
    op(1, 0, 3'b101, 64'h1006, 0, 4,
       64'hBEEF_0000_0000_0000);

    push(0, 1, 64'h2000, 64'h1234_5678_0000_0000,
         8'hF0, 64'hBEEF, 2, 1);
    op(0, 1, 3'b010, 64'h2004,
       64'h1234_5678, 1, 64'hDEAD);

    push(0, 1, 64'h6000, 64'hAB00_0000_0000_0000,
         8'h80, 64'hBEEF, 2, 1);
    op(0, 1, 3'b000, 64'h6007, 64'hAB, 1, 0);

    push(0, 1, 64'h6000, 64'h0000_0000_CAFE_0000,
         8'h0C, 64'hBEEF, 2, 1);
    op(0, 1, 3'b001, 64'h6002, 64'hCAFE, 1, 0);

    push(0, 0, 64'h4000, 0, 8'h00,
         64'hFFFF_FFFF_8765_4321, 3, 2);
    op(1, 0, 3'b010, 64'h4004, 0, 2,
       64'h8765_4321_0000_0000);

    push(1, 0, 0, 0, 0, 0, 0, 0);
    op(1, 0, 3'b010, 64'h3002, 0, -1, 0);
    chk("mis_noreq", mem_req_o, 0);

    push(1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 1, 3'b011, 64'h3004, 0, -1, 0);

    memRead_i = 1; memWrite_i = 1;
    funct3_i = 3'b011; addr_i = 64'h8000;
    @(negedge clk);
    chk("noop_stall", stall_o, 0);
    chk("noop_mis", misalign_o, 0);
    @(posedge clk) #1;
    memRead_i = 0; memWrite_i = 0;
    chk("noop_req", mem_req_o, 0);
    mem_ack_i = 1; mem_rdata_i = 64'h5555;
    @(posedge clk) #1;
    mem_ack_i = 0; mem_rdata_i = 0;
    chk("idle_ack", readData_o,
        64'hFFFF_FFFF_8765_4321);
    chk("idle_ack_req", mem_req_o, 0);

    push(2, 0, 64'h5008, 0, 8'h00, 0, 6, 5);
    op(1, 0, 3'b011, 64'h5008, 0, 0, 0);

    push(0, 0, 64'h5000, 0, 8'h00,
         64'h0123_4567_89AB_CDEF, 2, 1);
    op(1, 0, 3'b011, 64'h5000, 0, 1,
       64'h0123_4567_89AB_CDEF);

    memRead_i = 1; funct3_i = 3'b011;
    addr_i = 64'h7000;
    @(posedge clk) #1;
    memRead_i = 0;
    @(posedge clk) #1;
    reset = 1;
    @(posedge clk) #1;
    reset = 0;
    chk("rw_req", mem_req_o, 0);
    mem_ack_i = 1; mem_rdata_i = 64'hFFFF;
    @(posedge clk) #1;
    mem_ack_i = 0; mem_rdata_i = 0;
    chk("rw_rdata", readData_o, 0);
    chk("rw_stall", stall_o, 0);
    chk("rw_req2", mem_req_o, 0);
    chk("rw_addr", mem_addr_o, 0);
    chk("rw_strb", mem_wstrb_o, 0);
    chk("rw_err", busErr_o, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
